shared_alu_sched: RTL and testbench

- Multi-cycle scheduled controller that computes the compare/select/shift dataflow (d=a+b, e=a+c, f=a−b, signed compare, two-level select, 1-bit shifts, 32-bit truncation) with one shared 64-bit add/sub/compare unit.
- Sequences that unit through a fixed state schedule.
- Replaces the fully parallel generated datapath where area matters more than throughput.
- Start/Done handshake toward the surrounding design.

---
 rtl/shared_alu_sched_pkg.sv | 22 ++
 rtl/sched_alu.sv | 50 +++++
 rtl/shared_alu_sched.sv | 213 +++++++++++++++++++++
 tb/tb_shared_alu_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_alu_sched_pkg.sv
// shared_alu_sched_pkg
// Shared types for the scheduled compare/select/shift controller.
//   state_e  : controller schedule, one state per shared-unit step
//   alu_op_e : operation select for the shared add/sub/compare unit
package shared_alu_sched_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StOpD     = 3'd1,
        StOpE     = 3'd2,
        StOpF     = 3'd3,
        StOpCmp   = 3'd4,
        StOpShift = 3'd5,
        StDone    = 3'd6
    } state_e;

    typedef enum logic {
        OpAdd = 1'b0,
        OpSub = 1'b1
    } alu_op_e;

endpackage

// File: rtl/sched_alu.sv
// sched_alu
// Combinational signed add/sub/compare unit shared by every step of the schedule.
// Configuration macro: SHARED_ALU_SCHED_OVF_EN adds the signed-overflow output.
// Ports:
//   op_i   : OpAdd -> opa_i + opb_i, OpSub -> opa_i - opb_i
//   opa_i  : WIDTH-bit signed operand A
//   opb_i  : WIDTH-bit signed operand B
//   res_o  : WIDTH-bit result, wraps modulo 2^WIDTH
//   lt_o   : opa_i < opb_i (signed), valid for OpSub only
//   eq_o   : opa_i == opb_i, valid for OpSub only
//   ovf_o  : WIDTH-bit signed overflow of res_o (only with SHARED_ALU_SCHED_OVF_EN)
module sched_alu
    import shared_alu_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] res_o,
    output logic             lt_o,
    output logic             eq_o
`ifdef SHARED_ALU_SCHED_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    // One extra bit of sign extension: the WIDTH+1-bit difference can never
    // overflow, so its top bit is an exact signed less-than flag.
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] wide;

    always_comb begin
        ext_a = {opa_i[WIDTH-1], opa_i};
        ext_b = {opb_i[WIDTH-1], opb_i};
        wide  = (op_i == OpSub) ? (ext_a - ext_b) : (ext_a + ext_b);
    end

    assign res_o = wide[WIDTH-1:0];
    assign lt_o  = wide[WIDTH];
    assign eq_o  = (wide == '0);

`ifdef SHARED_ALU_SCHED_OVF_EN
    // Result does not fit in WIDTH signed bits when the two top bits disagree.
    assign ovf_o = wide[WIDTH] ^ wide[WIDTH-1];
`endif

endmodule

// File: rtl/shared_alu_sched.sv
// shared_alu_sched
// Multi-cycle controller computing
//   d = a+b, e = a+c, f = a-b, lt = d<e, eq = d==e,
//   g = lt ? e : d, h = eq ? f : g,
//   x = (h << lt)[OWIDTH-1:0], z = (g >>> eq)[OWIDTH-1:0]
// with a single shared add/sub/compare unit stepped through a fixed schedule.
// Configuration macro: SHARED_ALU_SCHED_OVF_EN adds the Ovf output (sticky
// overflow of the d/e/f steps, presented together with x/z).
// Ports:
//   Clk    : rising-edge clock
//   Rst    : synchronous active-low reset
//   Start  : request, sampled only while idle
//   a,b,c  : WIDTH-bit signed operands, latched on the accepting edge
//   Busy   : high in every state except idle
//   Done   : one-cycle pulse, x/z valid from this cycle on
//   x, z   : OWIDTH-bit signed results, held until the next Done or reset
//   Ovf    : overflow flag held with x/z (only with SHARED_ALU_SCHED_OVF_EN)
// OWIDTH must be smaller than WIDTH: only the low OWIDTH+1 bits of g and the
// low OWIDTH bits of f/h are kept, which is all the truncated results need.
module shared_alu_sched
    import shared_alu_sched_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned OWIDTH = 32
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic signed [WIDTH-1:0]  a,
    input  logic signed [WIDTH-1:0]  b,
    input  logic signed [WIDTH-1:0]  c,
    output logic                     Busy,
    output logic                     Done,
    output logic signed [OWIDTH-1:0] x,
    output logic signed [OWIDTH-1:0] z
`ifdef SHARED_ALU_SCHED_OVF_EN
    ,
    output logic                     Ovf
`endif
);

    state_e            state_q, state_d;

    logic [WIDTH-1:0]  a_q, b_q, c_q;
    logic [WIDTH-1:0]  d_q, e_q;
    logic [OWIDTH-1:0] f_q;
    logic [OWIDTH:0]   g_q;
    logic [OWIDTH-1:0] h_q;
    logic              lt_q, eq_q;
    logic [OWIDTH-1:0] x_q, z_q;

    alu_op_e           alu_op;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_res;
    logic              alu_lt, alu_eq;

    logic [OWIDTH:0]   g_sel;
    logic [OWIDTH-1:0] h_sel;

`ifdef SHARED_ALU_SCHED_OVF_EN
    logic              alu_ovf;
    logic              ovf_flag_q;
    logic              ovf_q;
`endif

    sched_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i  (alu_op),
        .opa_i (alu_a),
        .opb_i (alu_b),
        .res_o (alu_res),
        .lt_o  (alu_lt),
        .eq_o  (alu_eq)
`ifdef SHARED_ALU_SCHED_OVF_EN
        ,
        .ovf_o (alu_ovf)
`endif
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and shared-unit operand/op steering.
    always_comb begin
        state_d = state_q;
        alu_op  = OpAdd;
        alu_a   = a_q;
        alu_b   = b_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StOpD;
                end
            end
            StOpD: begin
                state_d = StOpE;
            end
            StOpE: begin
                alu_b   = c_q;
                state_d = StOpF;
            end
            StOpF: begin
                alu_op  = OpSub;
                state_d = StOpCmp;
            end
            StOpCmp: begin
                alu_op  = OpSub;
                alu_a   = d_q;
                alu_b   = e_q;
                state_d = StOpShift;
            end
            StOpShift: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Two-level select, only meaningful while the unit is comparing d and e.
    always_comb begin
        g_sel = alu_lt ? e_q[OWIDTH:0] : d_q[OWIDTH:0];
        h_sel = alu_eq ? f_q : g_sel[OWIDTH-1:0];
    end

    // Datapath registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            d_q  <= '0;
            e_q  <= '0;
            f_q  <= '0;
            g_q  <= '0;
            h_q  <= '0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            x_q  <= '0;
            z_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        a_q <= a;
                        b_q <= b;
                        c_q <= c;
                    end
                end
                StOpD: d_q <= alu_res;
                StOpE: e_q <= alu_res;
                StOpF: f_q <= alu_res[OWIDTH-1:0];
                StOpCmp: begin
                    lt_q <= alu_lt;
                    eq_q <= alu_eq;
                    g_q  <= g_sel;
                    h_q  <= h_sel;
                end
                StOpShift: begin
                    x_q <= h_q << lt_q;
                    // Arithmetic shift right by one, truncated: bit OWIDTH of g
                    // is a real bit of g, so no sign fill is needed here.
                    z_q <= eq_q ? g_q[OWIDTH:1] : g_q[OWIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef SHARED_ALU_SCHED_OVF_EN
    // Sticky over the d/e/f steps; copied to the output alongside x/z so it
    // holds with the results while the next request runs.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ovf_flag_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        ovf_flag_q <= 1'b0;
                    end
                end
                StOpD, StOpE, StOpF: begin
                    ovf_flag_q <= ovf_flag_q | alu_ovf;
                end
                StOpShift: begin
                    ovf_q <= ovf_flag_q;
                end
                default: ;
            endcase
        end
    end

    assign Ovf = ovf_q;
`endif

    assign Busy = (state_q != StIdle);
    assign Done = (state_q == StDone);
    assign x    = x_q;
    assign z    = z_q;

endmodule

// File: tb/tb_shared_alu_sched.sv
// tb_shared_alu_sched
// Directed and randomized stimulus for shared_alu_sched, checked against a
// behavioural model evaluated with plain signed 64-bit arithmetic.
module tb_shared_alu_sched;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [63:0] a, b, c;
    logic        Busy, Done;
    logic [31:0] x, z;
`ifdef SHARED_ALU_SCHED_OVF_EN
    logic        Ovf;
`endif

    int checks = 0;
    int errors = 0;

    shared_alu_sched #(
        .WIDTH  (64),
        .OWIDTH (32)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .a     (a),
        .b     (b),
        .c     (c),
        .Busy  (Busy),
        .Done  (Done),
        .x     (x),
        .z     (z)
`ifdef SHARED_ALU_SCHED_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: evaluate the dataflow directly on signed integers.
    function automatic void model(input logic [63:0] ia, input logic [63:0] ib,
                                  input logic [63:0] ic, output logic [31:0] ex,
                                  output logic [31:0] ez, output logic eo);
        longint sa, sb, sc, d, e, f, g, h, xx, zz;
        bit lt, eq, od, oe, of;
        sa = ia;
        sb = ib;
        sc = ic;
        d  = sa + sb;
        e  = sa + sc;
        f  = sa - sb;
        lt = (d < e);
        eq = (d == e);
        g  = lt ? e : d;
        h  = eq ? f : g;
        xx = lt ? h * 2 : h;
        zz = eq ? (g - (g & 64'sd1)) / 2 : g;   // floor(g/2)
        ex = 32'(xx);
        ez = 32'(zz);
        od = ((sa < 0) == (sb < 0)) && ((d < 0) != (sa < 0));
        oe = ((sa < 0) == (sc < 0)) && ((e < 0) != (sa < 0));
        of = ((sa < 0) != (sb < 0)) && ((f < 0) != (sa < 0));
        eo = od | oe | of;
    endfunction

    // One request from idle: latency, results, post-Done state.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_, input logic [63:0] tc,
                         input string tag);
        logic [31:0] ex, ez;
        logic        eo;
        int          k;
        model(ta, tb_, tc, ex, ez, eo);
        @(negedge Clk);
        a     = ta;
        b     = tb_;
        c     = tc;
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        c     = {$urandom, $urandom};
        check({tag, "_busy"}, 64'(Busy), 64'd1);
        k = 1;
        while (Done !== 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'd6);
        check({tag, "_x"}, 64'(x), 64'(ex));
        check({tag, "_z"}, 64'(z), 64'(ez));
`ifdef SHARED_ALU_SCHED_OVF_EN
        check({tag, "_ovf"}, 64'(Ovf), 64'(eo));
`endif
        @(negedge Clk);
        check({tag, "_done_low"}, 64'({Busy, Done}), 64'd0);
        check({tag, "_x_hold"}, 64'(x), 64'(ex));
    endtask

    initial begin
        logic [31:0] ex, ez;
        logic        eo;
        int          last, ndone, k;
        logic [63:0] ra, rb, rc;

        Rst   = 1'b0;
        Start = 1'b0;
        a     = '0;
        b     = '0;
        c     = '0;
        repeat (2) @(negedge Clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_x", 64'(x), 64'd0);
        check("reset_z", 64'(z), 64'd0);
`ifdef SHARED_ALU_SCHED_OVF_EN
        check("reset_ovf", 64'(Ovf), 64'd0);
`endif
        Rst = 1'b1;

        do_op(64'd5, 64'd3, 64'd10, "lt_case");
        do_op(64'd5, 64'd3, 64'd3, "eq_case");
        do_op(-64'sd10, 64'd2, 64'd4, "neg_case");

        // Start held high, operands scrambled while busy.
        model(64'd5, 64'd3, 64'd10, ex, ez, eo);
        last  = -1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (!Busy) begin
                a = 64'd5;
                b = 64'd3;
                c = 64'd10;
            end else begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                c = {$urandom, $urandom};
            end
            Start = 1'b1;
            if (Done === 1'b1) begin
                ndone++;
                check("b2b_x", 64'(x), 64'(ex));
                check("b2b_z", 64'(z), 64'(ez));
                if (last >= 0) check("b2b_interval", 64'(i - last), 64'd7);
                last = i;
            end
        end
        check("b2b_count", 64'(ndone), 64'd5);
        Start = 1'b0;
        k = 0;
        while (Busy === 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        check("b2b_drain", 64'(Busy), 64'd0);

        // Reset while in the compare step.
        @(negedge Clk);
        a     = 64'd7;
        b     = 64'd1;
        c     = 64'd2;
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_x", 64'(x), 64'd0);
        check("abort_z", 64'(z), 64'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

`ifdef SHARED_ALU_SCHED_OVF_EN
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "ovf_set");
        check("ovf_set_flag", 64'(Ovf), 64'd1);
        do_op(64'd1, 64'd1, 64'd1, "ovf_clear");
        check("ovf_clear_flag", 64'(Ovf), 64'd0);
`endif

        // Randomized requests; some force c==b to hit the equal path.
        for (int i = 0; i < 25; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            if (i % 3 == 1) begin
                ra = 64'($signed($urandom_range(0, 200)) - 100);
                rb = 64'($signed($urandom_range(0, 200)) - 100);
                rc = 64'($signed($urandom_range(0, 200)) - 100);
            end
            if (i % 4 == 0) rc = rb;
            do_op(ra, rb, rc, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
